// File: rtl/tcm_boot_responder.sv
// Dual-port word RAM for CPU fetch/data ports, filled from a boot byte stream before CPU release.
// Optional: define BOOT_CSUM_EN to require a trailing 32-bit checksum of the loaded words.
module tcm_boot_responder #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned BOOT_BASE  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_valid,
    input  logic [7:0]  boot_byte,
    output logic        boot_ready,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err,
    input  logic [31:0] im_addr,
    input  logic [3:0]  im_w_en,
    input  logic [31:0] im_wdata,
    output logic [31:0] im_rdata,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_w_en,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata
);

    localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [31:0]           BOOT_ROOM = 32'(DEPTH - BOOT_BASE);
    localparam logic [ADDR_WIDTH-1:0] BASE_IDX  = ADDR_WIDTH'(BOOT_BASE);
    localparam logic [ADDR_WIDTH:0]   WCNT_ONE  = 1;

    localparam logic [2:0] ST_LEN  = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;
`ifdef BOOT_CSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd2;
    localparam logic [2:0] ST_POST = ST_CSUM;
`else
    localparam logic [2:0] ST_POST = ST_RUN;
`endif

    logic [31:0] mem [DEPTH];

    logic [2:0]            state;
    logic [1:0]            bcnt;
    logic [31:0]           shreg;
    logic [31:0]           len;
    logic [ADDR_WIDTH:0]   wcnt;
    logic                  fire;
    logic                  word_done;
    logic [31:0]           word_in;
    logic [ADDR_WIDTH-1:0] boot_idx;
    logic [ADDR_WIDTH-1:0] im_idx;
    logic [ADDR_WIDTH-1:0] dm_idx;
    logic                  unused_addr_bits;
`ifdef BOOT_CSUM_EN
    logic [31:0]           sum;
`endif

    assign fire      = boot_valid & boot_ready;
    // Bytes shift in from the top so the 4th byte completes a little-endian word.
    assign word_in   = {boot_byte, shreg[31:8]};
    assign word_done = fire && (bcnt == 2'd3);
    assign boot_idx  = BASE_IDX + wcnt[ADDR_WIDTH-1:0];
    assign im_idx    = im_addr[ADDR_WIDTH+1:2];
    assign dm_idx    = dm_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{im_addr[31:ADDR_WIDTH+2], im_addr[1:0],
                                dm_addr[31:ADDR_WIDTH+2], dm_addr[1:0]};

`ifdef BOOT_CSUM_EN
    assign boot_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
`else
    assign boot_ready = (state == ST_LEN) || (state == ST_DATA);
`endif
    assign cpu_rst   = (state != ST_RUN);
    assign load_done = (state == ST_RUN);
    assign load_err  = (state == ST_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LEN;
            bcnt  <= '0;
            shreg <= '0;
            len   <= '0;
            wcnt  <= '0;
`ifdef BOOT_CSUM_EN
            sum   <= '0;
`endif
        end else begin
            if (fire) begin
                bcnt  <= bcnt + 2'd1;
                shreg <= word_in;
            end
            if (word_done) begin
                case (state)
                    ST_LEN: begin
                        len  <= word_in;
                        wcnt <= '0;
                        if (word_in == '0)
                            state <= ST_POST;
                        else if (word_in > BOOT_ROOM)
                            state <= ST_ERR;
                        else
                            state <= ST_DATA;
                    end
                    ST_DATA: begin
                        wcnt <= wcnt + WCNT_ONE;
`ifdef BOOT_CSUM_EN
                        sum  <= sum + word_in;
`endif
                        if (32'(wcnt) + 32'd1 == len)
                            state <= ST_POST;
                    end
`ifdef BOOT_CSUM_EN
                    ST_CSUM: state <= (word_in == sum) ? ST_RUN : ST_ERR;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Data-port lanes are written after fetch-port lanes so they win on a same-word collision.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_DATA && word_done)
            mem[boot_idx] <= word_in;
        if (!rst && state == ST_RUN) begin
            for (int unsigned k = 0; k < 4; k++)
                if (im_w_en[k]) mem[im_idx][8*k +: 8] <= im_wdata[8*k +: 8];
            for (int unsigned k = 0; k < 4; k++)
                if (dm_w_en[k]) mem[dm_idx][8*k +: 8] <= dm_wdata[8*k +: 8];
        end
    end

    assign im_rdata = (state == ST_RUN) ? mem[im_idx] : '0;
    assign dm_rdata = (state == ST_RUN) ? mem[dm_idx] : '0;

endmodule
